// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/redirect sequencer.
// Stage vectors are indexed [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB.
package pipeline_ctrl_pkg;

    localparam int STAGE_NUM = 5;

    localparam int ST_PC    = 0;
    localparam int ST_IFID  = 1;
    localparam int ST_IDEX  = 2;
    localparam int ST_EXMEM = 3;
    localparam int ST_MEMWB = 4;

    typedef logic [STAGE_NUM-1:0] stage_vec_t;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_DIV_WAIT   = 2'd1,
        S_MEM_WAIT   = 2'd2,
        S_TRAP_DRAIN = 2'd3
    } state_e;

    // Each hazard holds everything upstream of the stalled stage and bubbles the next one.
    localparam stage_vec_t LU_STALL   = 5'b00011;
    localparam stage_vec_t LU_FLUSH   = 5'b00100;
    localparam stage_vec_t BR_FLUSH   = 5'b00110;
    localparam stage_vec_t DIV_STALL  = 5'b00111;
    localparam stage_vec_t DIV_FLUSH  = 5'b01000;
    localparam stage_vec_t MEM_STALL  = 5'b01111;
    localparam stage_vec_t MEM_FLUSH  = 5'b10000;
    localparam stage_vec_t TRAP_STALL = 5'b00001;
    localparam stage_vec_t TRAP_FLUSH = 5'b01110;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard request and pipeline control bundle between the core and pipeline_ctrl.
// master = core side (raises hazards), slave = the controller.
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    import pipeline_ctrl_pkg::*;

    logic                  load_use_stall_i;
    logic                  branch_taken_i;
    logic [ADDR_WIDTH-1:0] branch_target_i;
    logic                  div_req_i;
    logic                  div_done_i;
    logic                  div_start_o;
    logic                  mem_busy_i;
    logic                  trap_req_i;
    logic [ADDR_WIDTH-1:0] trap_vec_i;
    stage_vec_t            stall_o;
    stage_vec_t            flush_o;
    logic                  redirect_o;
    logic [ADDR_WIDTH-1:0] redirect_pc_o;
    logic                  bus_err_o;

    modport master (
        output load_use_stall_i, branch_taken_i, branch_target_i,
               div_req_i, div_done_i, mem_busy_i, trap_req_i, trap_vec_i,
        input  div_start_o, stall_o, flush_o, redirect_o, redirect_pc_o, bus_err_o
    );

    modport slave (
        input  load_use_stall_i, branch_taken_i, branch_target_i,
               div_req_i, div_done_i, mem_busy_i, trap_req_i, trap_vec_i,
        output div_start_o, stall_o, flush_o, redirect_o, redirect_pc_o, bus_err_o
    );

endinterface

// File: rtl/pipeline_ctrl_timer.sv
// Clearable up-counter with terminal-count compare; shared by the MEM timeout and trap drain.
module pipeline_ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] tc_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage core: priority mux, multi-cycle FSM, trap latch.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   S_RUN        | normal flow; single-cycle hazards resolved here by priority
//   S_DIV_WAIT   | EX held until the divider returns div_done_i
//   S_MEM_WAIT   | MEM held while the data bus is busy, bounded by MEM_TIMEOUT
//   S_TRAP_DRAIN | pipeline drained for TRAP_DRAIN cycles, then PC redirected
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TRAP_DRAIN  = 2
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  core_if
);

    localparam int CNT_MAX = (MEM_TIMEOUT > TRAP_DRAIN) ? MEM_TIMEOUT : TRAP_DRAIN;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    // Terminal count fires on the cycle whose increment would reach the limit.
    localparam logic [CNT_W-1:0] MEM_TC  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TRAP_TC = CNT_W'(TRAP_DRAIN - 1);

    state_e                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] vec_q, vec_d;
    logic                  bus_err_q, bus_err_d;

    logic                  tmr_clr;
    logic                  tmr_inc;
    logic                  tmr_tc;
    logic [CNT_W-1:0]      tmr_tc_val;

    stage_vec_t            stall;
    stage_vec_t            flush;
    logic                  div_start;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    pipeline_ctrl_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .tc_val_i (tmr_tc_val),
        .tc_o     (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            pend_q    <= 1'b0;
            vec_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            vec_q     <= vec_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        vec_d       = vec_q;
        bus_err_d   = bus_err_q;
        tmr_clr     = 1'b1;
        tmr_inc     = 1'b0;
        tmr_tc_val  = MEM_TC;
        stall       = '0;
        flush       = '0;
        div_start   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // A trap arriving mid-event waits; the first vector seen is the one serviced.
        if ((state_q == S_DIV_WAIT || state_q == S_MEM_WAIT) &&
            core_if.trap_req_i && !pend_q) begin
            pend_d = 1'b1;
            vec_d  = core_if.trap_vec_i;
        end

        case (state_q)
            S_RUN: begin
                if (pend_q || core_if.trap_req_i) begin
                    stall   = TRAP_STALL;
                    flush   = TRAP_FLUSH;
                    pend_d  = 1'b0;
                    if (!pend_q) begin
                        vec_d = core_if.trap_vec_i;
                    end
                    state_d = S_TRAP_DRAIN;
                end else if (core_if.mem_busy_i) begin
                    stall   = MEM_STALL;
                    flush   = MEM_FLUSH;
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                    state_d = S_MEM_WAIT;
                end else if (core_if.div_req_i) begin
                    div_start = 1'b1;
                    stall     = DIV_STALL;
                    flush     = DIV_FLUSH;
                    state_d   = S_DIV_WAIT;
                end else if (core_if.branch_taken_i) begin
                    flush       = BR_FLUSH;
                    redirect    = 1'b1;
                    redirect_pc = core_if.branch_target_i;
                end else if (core_if.load_use_stall_i) begin
                    stall = LU_STALL;
                    flush = LU_FLUSH;
                end
            end

            S_DIV_WAIT: begin
                if (core_if.div_done_i) begin
                    state_d = S_RUN;
                end else begin
                    stall = DIV_STALL;
                    flush = DIV_FLUSH;
                end
            end

            S_MEM_WAIT: begin
                if (core_if.mem_busy_i) begin
                    stall = MEM_STALL;
                    flush = MEM_FLUSH;
                    if (tmr_tc) begin
                        bus_err_d = 1'b1;
                        state_d   = S_RUN;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_inc = 1'b1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end

            S_TRAP_DRAIN: begin
                tmr_tc_val = TRAP_TC;
                stall      = TRAP_STALL;
                flush      = TRAP_FLUSH;
                if (tmr_tc) begin
                    redirect    = 1'b1;
                    redirect_pc = vec_q;
                    state_d     = S_RUN;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Combinational outputs are forced quiet for as long as reset is held.
    assign core_if.stall_o       = rst ? '0   : stall;
    assign core_if.flush_o       = rst ? '0   : flush;
    assign core_if.div_start_o   = rst ? 1'b0 : div_start;
    assign core_if.redirect_o    = rst ? 1'b0 : redirect;
    assign core_if.redirect_pc_o = rst ? '0   : redirect_pc;
    assign core_if.bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (MEM_TIMEOUT=4, TRAP_DRAIN=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    pipeline_ctrl #(
        .ADDR_WIDTH  (AW),
        .MEM_TIMEOUT (4),
        .TRAP_DRAIN  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .core_if (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // {stall[4:0], flush[4:0], div_start, redirect, redirect_pc[31:0], bus_err}
    logic [44:0] obs;
    logic [44:0] e;
    assign obs = {bus.stall_o, bus.flush_o, bus.div_start_o, bus.redirect_o,
                  bus.redirect_pc_o, bus.bus_err_o};

    function automatic logic [44:0] ex(input logic [4:0] s, input logic [4:0] f,
                                       input logic ds, input logic rd,
                                       input logic [31:0] pc, input logic be);
        return {s, f, ds, rd, pc, be};
    endfunction

    task automatic set_in(input logic lu, input logic br, input logic [31:0] tgt,
                          input logic dreq, input logic ddone, input logic busy,
                          input logic trap, input logic [31:0] vec);
        bus.load_use_stall_i = lu;
        bus.branch_taken_i   = br;
        bus.branch_target_i  = tgt;
        bus.div_req_i        = dreq;
        bus.div_done_i       = ddone;
        bus.mem_busy_i       = busy;
        bus.trap_req_i       = trap;
        bus.trap_vec_i       = vec;
    endtask

    task automatic drive(input logic lu, input logic br, input logic [31:0] tgt,
                         input logic dreq, input logic ddone, input logic busy,
                         input logic trap, input logic [31:0] vec);
        @(negedge clk);
        set_in(lu, br, tgt, dreq, ddone, busy, trap, vec);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 1, 32'h80, 1, 0, 0, 0, 0);
        #2;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL reset_hold: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL reset_release: got %h want %h", obs, e); end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            e = ex(5'b00011, 5'b00100, 0, 0, 0, 0); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL load_use_c%0d: got %h want %h", i, obs, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL load_use_after: got %h want %h", obs, e); end
    endtask

    task automatic test_branch();
        drive(1, 1, 32'h80, 0, 0, 0, 0, 0);
        e = ex(0, 5'b00110, 0, 1, 32'h80, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL branch_over_lu: got %h want %h", obs, e); end
        drive(0, 0, 32'h80, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL branch_after: got %h want %h", obs, e); end
    endtask

    task automatic test_div();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(5'b00111, 5'b01000, 1, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL div_start: got %h want %h", obs, e); end
        for (int i = 1; i < 5; i++) begin
            drive(1, 1, 32'h40, 1, 0, 0, 0, 0);
            e = ex(5'b00111, 5'b01000, 0, 0, 0, 0); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL div_wait_c%0d: got %h want %h", i, obs, e); end
        end
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL div_done: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL div_after: got %h want %h", obs, e); end
    endtask

    task automatic test_trap_pending();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(5'b00111, 5'b01000, 1, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_start: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 0, 0, 1, 32'h100);
        e = ex(5'b00111, 5'b01000, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_div: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 1, 0, 1, 32'h200);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_done: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_enter: got %h want %h", obs, e); end
        drive(1, 1, 32'h80, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_drain0: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 1, 32'h100, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_redirect: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tpend_after: got %h want %h", obs, e); end
    endtask

    task automatic test_trap_run();
        drive(1, 1, 32'h80, 1, 0, 1, 1, 32'h300);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL trap_priority: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 32'h999);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL trap_drain0: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 1, 32'h300, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL trap_redirect: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL trap_single_pulse: got %h want %h", obs, e); end
    endtask

    task automatic test_div_mem();
        drive(0, 0, 0, 1, 0, 1, 0, 0);
        e = ex(5'b01111, 5'b10000, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL divmem_mem_first: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL divmem_release: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(5'b00111, 5'b01000, 1, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL divmem_div_start: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL divmem_done: got %h want %h", obs, e); end
    endtask

    task automatic test_mem_short();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            e = ex(5'b01111, 5'b10000, 0, 0, 0, 0); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL mem_a_c%0d: got %h want %h", i, obs, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL mem_a_release: got %h want %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, (i == 1), 32'h500);
            e = ex(5'b01111, 5'b10000, 0, 0, 0, 0); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL mem_b_c%0d: got %h want %h", i, obs, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL mem_b_release: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL mem_trap_enter: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL mem_trap_drain0: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 1, 32'h500, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL mem_trap_redirect: got %h want %h", obs, e); end
    endtask

    task automatic test_mem_timeout();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            e = ex(5'b01111, 5'b10000, 0, 0, 0, 0); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL tmo_busy_c%0d: got %h want %h", i, obs, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 1); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tmo_bus_err_set: got %h want %h", obs, e); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00011, 5'b00100, 0, 0, 0, 1); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL tmo_sticky: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(5'b00111, 5'b01000, 1, 0, 0, 1); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_div_start: got %h want %h", obs, e); end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        e = ex(5'b00111, 5'b01000, 0, 0, 0, 1); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_div_wait: got %h want %h", obs, e); end
        rst = 1'b1;
        #1;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_div_rst: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_div_run: got %h want %h", obs, e); end

        drive(0, 0, 0, 0, 0, 0, 1, 32'h400);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_trap_enter: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(5'b00001, 5'b01110, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_trap_drain0: got %h want %h", obs, e); end
        rst = 1'b1;
        #1;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_trap_rst: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_trap_run: got %h want %h", obs, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e = ex(0, 0, 0, 0, 0, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_no_redirect: got %h want %h", obs, e); end
        drive(0, 1, 32'h44, 0, 0, 0, 0, 0);
        e = ex(0, 5'b00110, 0, 1, 32'h44, 0); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL rmid_branch: got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_div();
        test_trap_pending();
        test_trap_run();
        test_div_mem();
        test_mem_short();
        test_mem_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
